// File: rtl/shift_right_iter_pkg.sv
// ============================================================================
// shift_right_iter_pkg : shared encodings for the iterative right shifter
// Rev 1.0
// ============================================================================
`default_nettype none

package shift_right_iter_pkg;

  localparam int C_DEF_DATA_WIDTH  = 32;
  localparam int C_DEF_SHAMT_WIDTH = 5;

  // FSM encodings; kept as plain constants so legacy decode logic can reuse them
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // ALU opcodes that route to the shift path
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;
  localparam logic [4:0] OP_SRL = 5'b00110;

  function automatic int stage_idx_width(input int shamt_width);
    return (shamt_width > 1) ? $clog2(shamt_width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_right_iter_if.sv
// ============================================================================
// shift_right_iter_if : start/ready handshake bundle for the right shifter
// Rev 1.0
// ============================================================================
`default_nettype none

interface shift_right_iter_if
  import shift_right_iter_pkg::*;
#(
  parameter int DATA_WIDTH  = C_DEF_DATA_WIDTH,
  parameter int SHAMT_WIDTH = C_DEF_SHAMT_WIDTH
);

  logic                   ctrl_shift;
  logic                   ctrl_arith;
  logic [DATA_WIDTH-1:0]  data_operand;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  data_result;
  logic                   data_resultRDY;
  logic                   busy;

  modport master (
    output ctrl_shift, ctrl_arith, data_operand, shamt,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_shift, ctrl_arith, data_operand, shamt,
    output data_result, data_resultRDY, busy
  );

endinterface

`default_nettype wire

// File: rtl/shift_right_iter_sr_stage.sv
// ============================================================================
// sr_stage : combinational right shift by 2^k, vacated bits take fill
// Rev 1.0
// ============================================================================
`default_nettype none

module sr_stage
  import shift_right_iter_pkg::*;
#(
  parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int K_WIDTH    = 3
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  fill_i,
  input  logic [K_WIDTH-1:0]    k_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  int step;

  always_comb begin
    step   = 1 << k_i;
    data_o = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i + step < DATA_WIDTH)
        data_o[i] = data_i[i + step];
      else
        data_o[i] = fill_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_right_iter.sv
// ============================================================================
// shift_right_iter : multi-cycle SRL/SRA, one power-of-two stage per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module shift_right_iter
  import shift_right_iter_pkg::*;
#(
  parameter int DATA_WIDTH  = C_DEF_DATA_WIDTH,
  parameter int SHAMT_WIDTH = C_DEF_SHAMT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  shift_right_iter_if.slave  bus
);

  localparam int K_WIDTH = stage_idx_width(SHAMT_WIDTH);
  localparam logic [K_WIDTH-1:0] C_K_TOP = K_WIDTH'(SHAMT_WIDTH - 1);

  logic [1:0]             state_q,  state_d;
  logic [DATA_WIDTH-1:0]  acc_q,    acc_d;
  logic [SHAMT_WIDTH-1:0] shamt_q,  shamt_d;
  logic                   fill_q,   fill_d;
  logic [K_WIDTH-1:0]     k_q,      k_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   rdy_q,    rdy_d;
  logic [DATA_WIDTH-1:0]  stage_out;
  logic [DATA_WIDTH-1:0]  acc_next;

  sr_stage #(
    .DATA_WIDTH (DATA_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_stage (
    .data_i (acc_q),
    .fill_i (fill_q),
    .k_i    (k_q),
    .data_o (stage_out)
  );

  assign acc_next = shamt_q[k_q] ? stage_out : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    shamt_d  = shamt_q;
    fill_d   = fill_q;
    k_d      = k_q;
    result_d = result_q;
    rdy_d    = 1'b0;
    case (state_q)
      // DONE accepts a new start exactly like IDLE so ops can issue back-to-back
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.ctrl_shift) begin
          acc_d   = bus.data_operand;
          shamt_d = bus.shamt;
          fill_d  = bus.ctrl_arith & bus.data_operand[DATA_WIDTH-1];
          k_d     = C_K_TOP;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_next;
        k_d   = k_q - 1'b1;
        if (k_q == '0) begin
          result_d = acc_next;
          rdy_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      shamt_q  <= '0;
      fill_q   <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      shamt_q  <= shamt_d;
      fill_q   <= fill_d;
      k_q      <= k_d;
      result_q <= result_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = (state_q == ST_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_shift_right_iter.sv
// ============================================================================
// tb_shift_right_iter : directed vectors, queue scoreboard on RDY pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_shift_right_iter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  shift_right_iter_if #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) bus ();

  shift_right_iter #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
    end
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && bus.data_resultRDY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.data_result, e.data);
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Call just after a negedge; the start is sampled at the next posedge (E0)
  task automatic start_op(input logic arith, input logic [31:0] op,
                          input logic [4:0] sh, input logic [31:0] want);
    exp_t e;
    bus.ctrl_shift   = 1'b1;
    bus.ctrl_arith   = arith;
    bus.data_operand = op;
    bus.shamt        = sh;
    e.data = want;
    e.cyc  = cyc + 6;
    exp_q.push_back(e);
    @(negedge clock);
    bus.ctrl_shift = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (n >= 30) check("drain_timeout", 32'd1, 32'd0);
    @(negedge clock);
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    while (bus.data_resultRDY !== 1'b1 && n < 30) begin
      @(negedge clock);
      n++;
    end
    if (n >= 30) check("rdy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.ctrl_shift   = 1'b0;
    bus.ctrl_arith   = 1'b0;
    bus.data_operand = '0;
    bus.shamt        = '0;
    repeat (3) @(negedge clock);
    check("reset_result", bus.data_result, 32'h0);
    check("reset_rdy", 32'(bus.data_resultRDY), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // 1: SRL full-width shift, busy visible mid-op
    start_op(1'b0, 32'h8000_0000, 5'd31, 32'h0000_0001);
    check("busy_mid_op", 32'(bus.busy), 32'h1);
    wait_idle();
    check("stale_result_idle", bus.data_result, 32'h0000_0001);
    check("idle_busy", 32'(bus.busy), 32'h0);

    // 2: SRA sign fill
    start_op(1'b1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    wait_idle();
    start_op(1'b1, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF);
    wait_idle();

    // 3: shamt=0 keeps full latency; small SRA
    start_op(1'b1, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    wait_idle();
    start_op(1'b1, 32'hDEAD_BEEF, 5'd4, 32'hFDEA_DBEE);
    wait_idle();

    // 4: new start and operand while busy must be ignored
    start_op(1'b0, 32'h0000_F000, 5'd12, 32'h0000_000F);
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_shift   = 1'b1;
      bus.ctrl_arith   = 1'b1;
      bus.data_operand = 32'hFFFF_FFFF;
      bus.shamt        = 5'd1;
      @(negedge clock);
    end
    bus.ctrl_shift = 1'b0;
    wait_idle();

    // 5: reset after E2 aborts with no RDY
    start_op(1'b0, 32'h1234_5678, 5'd3, 32'h0246_8ACF);
    @(negedge clock);
    reset = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clock);
    check("abort_result", bus.data_result, 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_rdy", 32'(bus.data_resultRDY), 32'h0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    start_op(1'b0, 32'h0000_0100, 5'd8, 32'h0000_0001);
    wait_idle();

    // 6: back-to-back issue from the DONE cycle, pulses 6 cycles apart
    start_op(1'b0, 32'h0000_00FF, 5'd4, 32'h0000_000F);
    wait_rdy();
    start_op(1'b1, 32'hF000_0000, 5'd4, 32'hFF00_0000);
    wait_idle();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
